// File: rtl/mano_cache_sa2.sv
// Two-way set-associative one-word-line cache, LRU replacement, write-back or write-through policy.
// Read hit: ready 2 cycles after request; misses add one memory round-trip per memory phase (plus RESP on fills).
module mano_cache_sa2 #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8,
    parameter bit WB      = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ready,
    output logic              cache_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, FILL, WTHRU, RESP} state_t;

    state_t            state;
    logic [SETS-1:0]   vld [2];
    logic [SETS-1:0]   dty [2];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tag_mem [2][SETS];
    logic [DATA_W-1:0] dat_mem [2][SETS];

    logic [ADDR_W-1:0] a_q;
    logic              we_q;
    logic [DATA_W-1:0] din_q;
    logic              vic_q;
    logic              hit_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic               hit0, hit1, hit, vic, vic_dirty;
    logic               arr_we, arr_way, touch, done, done_hit;
    logic [DATA_W-1:0]  arr_dat;

    assign idx  = a_q[INDEX_W-1:0];
    assign tg   = a_q[ADDR_W-1:INDEX_W];
    assign hit0 = vld[0][idx] && (tag_mem[0][idx] == tg);
    assign hit1 = vld[1][idx] && (tag_mem[1][idx] == tg);
    assign hit  = hit0 || hit1;
    // Fill an empty way first (way0 preferred), otherwise evict the LRU way.
    assign vic       = !vld[0][idx] ? 1'b0 : (!vld[1][idx] ? 1'b1 : lru[idx]);
    assign vic_dirty = WB && vld[vic][idx] && dty[vic][idx];

    always_comb begin
        arr_we   = 1'b0;
        arr_way  = 1'b0;
        arr_dat  = din_q;
        touch    = 1'b0;
        done     = 1'b0;
        done_hit = 1'b0;
        case (state)
            LOOKUP: begin
                if (hit) begin
                    touch    = 1'b1;
                    arr_way  = hit1;
                    arr_we   = we_q;
                    done     = !(we_q && !WB);
                    done_hit = 1'b1;
                end else if (we_q && WB && !vic_dirty) begin
                    touch   = 1'b1;
                    arr_way = vic;
                    arr_we  = 1'b1;
                    done    = 1'b1;
                end
            end
            WBACK: begin
                if (mem_req && mem_ack && we_q) begin
                    touch   = 1'b1;
                    arr_way = vic_q;
                    arr_we  = 1'b1;
                    done    = 1'b1;
                end
            end
            FILL: begin
                if (mem_req && mem_ack) begin
                    touch   = 1'b1;
                    arr_way = vic_q;
                    arr_we  = 1'b1;
                    arr_dat = mem_din;
                end
            end
            WTHRU: begin
                if (mem_req && mem_ack) begin
                    done     = 1'b1;
                    done_hit = hit_q;
                end
            end
            RESP:    done = 1'b1;
            default: ;
        endcase
    end

    // Tag/data storage needs no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[arr_way][idx] <= tg;
            dat_mem[arr_way][idx] <= arr_dat;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            vld[0]    <= '0;
            vld[1]    <= '0;
            dty[0]    <= '0;
            dty[1]    <= '0;
            lru       <= '0;
            cpu_ready <= 1'b0;
            cache_hit <= 1'b0;
            cpu_dout  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_dout  <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            a_q       <= '0;
            we_q      <= 1'b0;
            din_q     <= '0;
            vic_q     <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            if (touch) begin
                lru[idx] <= ~arr_way;
                if (arr_we) begin
                    vld[arr_way][idx] <= 1'b1;
                    dty[arr_way][idx] <= WB && we_q;
                end
            end
            if (done) begin
                cpu_ready <= 1'b1;
                cache_hit <= done_hit;
                if (done_hit) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        a_q   <= cpu_addr;
                        we_q  <= cpu_we;
                        din_q <= cpu_din;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit;
                    vic_q <= vic;
                    if (hit && !we_q) cpu_dout <= hit1 ? dat_mem[1][idx] : dat_mem[0][idx];
                    if (we_q && !WB) begin
                        state    <= WTHRU;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= a_q;
                        mem_dout <= din_q;
                    end else if (hit) begin
                        state <= IDLE;
                    end else if (vic_dirty) begin
                        state    <= WBACK;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= {tag_mem[vic][idx], idx};
                        mem_dout <= dat_mem[vic][idx];
                    end else if (we_q) begin
                        state <= IDLE;
                    end else begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= a_q;
                    end
                end
                WBACK: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= we_q ? IDLE : FILL;
                    end
                end
                FILL: begin
                    // Entered from WBACK with mem_req low: raise it after the one-cycle gap.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= a_q;
                    end else if (mem_ack) begin
                        mem_req  <= 1'b0;
                        cpu_dout <= mem_din;
                        state    <= RESP;
                    end
                end
                WTHRU: begin
                    if (mem_req && mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mano_cache_sa2.sv
// Scoreboard bench: dut 0 is write-back with 4-bit counters, dut 1 is write-through.
// Expectations come from a per-set recency-list model and a golden word memory.
module tb_mano_cache_sa2;
    logic        clk = 1'b0;
    logic        clr;
    logic        cpu_req [2];
    logic        cpu_we [2];
    logic [11:0] cpu_addr [2];
    logic [15:0] cpu_din [2];
    logic [15:0] cpu_dout [2];
    logic        cpu_ready [2];
    logic        cache_hit [2];
    logic        mem_req [2];
    logic        mem_we [2];
    logic [11:0] mem_addr [2];
    logic [15:0] mem_dout [2];
    logic [15:0] mem_din [2];
    logic        mem_ack [2];
    logic [3:0]  hc0, mc0;
    logic [15:0] hc1, mc1;
    logic [15:0] hit_cnt [2];
    logic [15:0] miss_cnt [2];
    logic        hold_mem [2];

    assign hit_cnt[0]  = {12'd0, hc0};
    assign miss_cnt[0] = {12'd0, mc0};
    assign hit_cnt[1]  = hc1;
    assign miss_cnt[1] = mc1;

    always #5 clk = ~clk;

    mano_cache_sa2 #(.ADDR_W(12), .DATA_W(16), .INDEX_W(8), .WB(1'b1), .CNT_W(4)) dut_wb (
        .clk(clk), .clr(clr), .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]),
        .cpu_din(cpu_din[0]), .cpu_dout(cpu_dout[0]), .cpu_ready(cpu_ready[0]), .cache_hit(cache_hit[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_dout(mem_dout[0]),
        .mem_din(mem_din[0]), .mem_ack(mem_ack[0]), .hit_cnt(hc0), .miss_cnt(mc0));

    mano_cache_sa2 #(.ADDR_W(12), .DATA_W(16), .INDEX_W(8), .WB(1'b0), .CNT_W(16)) dut_wt (
        .clk(clk), .clr(clr), .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]),
        .cpu_din(cpu_din[1]), .cpu_dout(cpu_dout[1]), .cpu_ready(cpu_ready[1]), .cache_hit(cache_hit[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_dout(mem_dout[1]),
        .mem_din(mem_din[1]), .mem_ack(mem_ack[1]), .hit_cnt(hc1), .miss_cnt(mc1));

    typedef struct {
        bit          we;
        bit          hit;
        bit          fast;
        logic [15:0] data;
        int          nrd;
        int          nwr;
        int          hcnt;
        int          mcnt;
        int          t;
    } exp_t;

    typedef struct {
        logic [3:0] tag;
        bit         dirty;
    } line_t;

    exp_t        scq [2][$];
    line_t       sets [512][$];
    logic [15:0] gold [int];
    logic [15:0] ram [int];
    int          hits [2];
    int          misses [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          nrd [2];
    int          nwr [2];
    int          last_rd [2];
    int          last_wr [2];
    int          wait_n [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memval(input logic [11:0] a);
        logic [15:0] x;
        x = {4'h0, a} * 16'h9E37;
        return (a == 12'h105) ? 16'hABCD : (x ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] gold_of(input int k);
        return gold.exists(k) ? gold[k] : memval(12'(k % 4096));
    endfunction

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", nm, d, $time, act, exp);
        end
    endtask

    // Memory responder and response monitor, both sampling on the falling edge.
    initial begin
        exp_t e;
        int   k;
        for (int d = 0; d < 2; d++) begin
            mem_ack[d] = 1'b0; mem_din[d] = '0; wait_n[d] = 0;
            nrd[d] = 0; nwr[d] = 0; last_rd[d] = 0; last_wr[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!clr) begin
                    scq[d].delete();
                    mem_ack[d] = 1'b0;
                    chk("rst_mem_req", d, mem_req[d], 0);
                    chk("rst_mem_we", d, mem_we[d], 0);
                    chk("rst_cpu_ready", d, cpu_ready[d], 0);
                    chk("rst_cache_hit", d, cache_hit[d], 0);
                    chk("rst_cpu_dout", d, cpu_dout[d], 0);
                    chk("rst_mem_addr", d, mem_addr[d], 0);
                    chk("rst_hit_cnt", d, hit_cnt[d], 0);
                    chk("rst_miss_cnt", d, miss_cnt[d], 0);
                end else begin
                    if (mem_ack[d]) begin
                        mem_ack[d] = 1'b0;
                    end else if (mem_req[d] && !hold_mem[d]) begin
                        if (wait_n[d] > 0) begin
                            wait_n[d]--;
                        end else begin
                            k = d * 4096 + int'(mem_addr[d]);
                            if (mem_we[d]) begin
                                chk("mem_wdata", d, mem_dout[d], gold_of(k));
                                ram[k] = mem_dout[d];
                                nwr[d]++;
                            end else begin
                                mem_din[d] = ram.exists(k) ? ram[k] : memval(mem_addr[d]);
                                nrd[d]++;
                            end
                            mem_ack[d] = 1'b1;
                            wait_n[d] = $urandom_range(0, 3);
                        end
                    end
                    if (cpu_ready[d]) begin
                        if (scq[d].size() == 0) begin
                            chk("ready_without_request", d, scq[d].size(), 1);
                        end else begin
                            e = scq[d].pop_front();
                            chk("cache_hit", d, cache_hit[d], e.hit);
                            if (!e.we) chk("cpu_dout", d, cpu_dout[d], e.data);
                            chk("mem_reads", d, nrd[d] - last_rd[d], e.nrd);
                            chk("mem_writes", d, nwr[d] - last_wr[d], e.nwr);
                            chk("hit_cnt", d, hit_cnt[d], e.hcnt);
                            chk("miss_cnt", d, miss_cnt[d], e.mcnt);
                            if (e.fast) chk("hit_latency", d, cyc - e.t, 2);
                        end
                        last_rd[d] = nrd[d];
                        last_wr[d] = nwr[d];
                    end else if (scq[d].size() != 0 && cyc - scq[d][0].t > 400) begin
                        chk("ready_timeout_cycles", d, cyc - scq[d][0].t, 400);
                        e = scq[d].pop_front();
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 512; s++) sets[s].delete();
        for (int d = 0; d < 2; d++) begin hits[d] = 0; misses[d] = 0; end
        // Dirty lines die with the reset, so memory becomes the truth again.
        gold.delete();
        foreach (ram[k]) gold[k] = ram[k];
    endtask

    task automatic issue(input int d, input bit we, input logic [11:0] a, input logic [15:0] din);
        exp_t  e;
        line_t ln;
        int    s, pos, cmax;
        bit    wb;
        s = d * 256 + int'(a[7:0]);
        pos = -1;
        wb = (d == 0);
        cmax = (d == 0) ? 15 : 65535;
        for (int i = 0; i < sets[s].size(); i++) if (sets[s][i].tag == a[11:8]) pos = i;
        e.we = we; e.hit = (pos >= 0); e.fast = 1'b0; e.nrd = 0; e.nwr = 0;
        e.data = gold_of(d * 4096 + int'(a)); e.t = cyc;
        if (pos >= 0) begin
            ln = sets[s][pos];
            sets[s].delete(pos);
            if (we && wb) ln.dirty = 1'b1;
            if (we && !wb) e.nwr = 1; else e.fast = 1'b1;
            sets[s].push_front(ln);
        end else if (we && !wb) begin
            e.nwr = 1;
        end else begin
            if (sets[s].size() == 2) begin
                ln = sets[s].pop_back();
                if (ln.dirty) e.nwr = 1;
            end
            e.nrd = we ? 0 : 1;
            ln.tag = a[11:8];
            ln.dirty = we;
            sets[s].push_front(ln);
        end
        if (we) gold[d * 4096 + int'(a)] = din;
        if (e.hit) begin if (hits[d] < cmax) hits[d]++; end
        else begin if (misses[d] < cmax) misses[d]++; end
        e.hcnt = hits[d];
        e.mcnt = misses[d];
        cpu_we[d] = we; cpu_addr[d] = a; cpu_din[d] = din; cpu_req[d] = 1'b1;
        scq[d].push_back(e);
    endtask

    task automatic finish_req(input int d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready[d] && n < 500);
        cpu_req[d] = 1'b0;
    endtask

    task automatic access(input int d, input bit we, input logic [11:0] a, input logic [15:0] din);
        issue(d, we, a, din);
        finish_req(d);
    endtask

    initial begin
        int n;
        clr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_din[d] = '0; hold_mem[d] = 1'b0;
            hits[d] = 0; misses[d] = 0;
        end
        #2 clr = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Write-back directed sequence on set 0x05.
        access(0, 0, 12'h105, 0);
        access(0, 0, 12'h105, 0);
        access(0, 0, 12'h205, 0);
        access(0, 1, 12'h105, 16'h1111);
        access(0, 0, 12'h305, 0);
        access(0, 0, 12'h205, 0);
        access(0, 1, 12'h305, 16'h2222);
        access(0, 0, 12'h205, 0);
        access(0, 1, 12'h405, 16'h3333);
        access(0, 0, 12'h405, 0);

        // Write-through: no allocation on write miss, write hits still go to memory.
        access(1, 1, 12'h010, 16'h5A5A);
        access(1, 0, 12'h010, 0);
        access(1, 0, 12'h010, 0);
        access(1, 1, 12'h010, 16'h1234);
        access(1, 0, 12'h010, 0);

        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 2; d++) begin
                issue(d, $urandom_range(0, 2) == 0, {4'($urandom_range(0, 7)), 8'($urandom_range(5, 7))},
                      16'($urandom));
                if ($urandom_range(0, 1) == 0) finish_req(d);
                else begin
                    finish_req(d);
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
            end
        end

        // Reset while a fill is outstanding.
        hold_mem[0] = 1'b1;
        issue(0, 0, 12'h040, 0);
        n = 0;
        while (!(mem_req[0] && !mem_we[0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 clr = 1'b0;
        cpu_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        model_reset();
        hold_mem[0] = 1'b0;
        @(negedge clk);

        // Miss after reset, then enough hits to pin the 4-bit hit counter.
        for (int i = 0; i < 20; i++) access(0, 0, 12'h040, 0);
        access(0, 0, 12'h105, 0);
        access(1, 0, 12'h010, 0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mano_cache_sa2.md
# mano_cache_sa2

Parametrised two-way set-associative, one-word-line cache between the MANO CPU and main memory, with a valid/ready handshake on both sides. Next generation of the direct-mapped cache: selectable write-back/write-allocate or write-through/no-allocate policy, LRU replacement, dirty-victim writeback, and saturating hit/miss counters. It sits on the CPU memory path; memory may take any number of cycles to acknowledge.

## Interface
- ADDR_W, 12, address width (bits)
- DATA_W, 16, word width
- INDEX_W, 8, set index width; tag width is TAG_W = ADDR_W-INDEX_W; sets = 2^INDEX_W
- WB, 1, 1 = write-back/write-allocate, 0 = write-through/no-allocate
- CNT_W, 16, statistic counter width
- clk  in  1  clock; everything updates on the rising edge
- clr  in  1  reset; asynchronous and active-low
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_din  in  DATA_W  write data
- cpu_dout  out  DATA_W  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cache_hit  out  1  hit/miss of the completing access; valid while cpu_ready=1
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_dout  out  DATA_W  cache-to-memory write data
- mem_din  in  DATA_W  memory-to-cache read data; sampled with mem_ack
- mem_ack  in  1  memory completion; single-cycle pulse
- hit_cnt, miss_cnt  out  CNT_W  saturating access counters

## Operation
- Address split: index = cpu_addr[INDEX_W-1:0]; tag = cpu_addr[ADDR_W-1:INDEX_W].
- Each way holds per set: valid, dirty, tag, data. Each set holds one LRU bit naming the least-recently-used way.
- States: IDLE, LOOKUP, WBACK, FILL, WTHRU, RESP.
- IDLE: if cpu_req=1, latch addr, we and din, then go to LOOKUP. Otherwise stay.
- LOOKUP, read hit: cpu_dout = way data; cache_hit=1; LRU points to the other way; go to IDLE with cpu_ready pulsed.
- LOOKUP, write hit:
  - WB=1: write the data, set dirty=1, update LRU, pulse ready.
  - WB=0: write the data, keep dirty=0, update LRU, go to WTHRU.
- Victim on a miss: the first invalid way (way0 preferred), otherwise the LRU way.
- LOOKUP, read miss: if WB=1 and the victim is dirty, go to WBACK; else go to FILL.
- LOOKUP, write miss:
  - WB=1: if the victim is dirty, go to WBACK. Then install directly with no fill: tag, data, valid=1, dirty=1, update LRU, pulse ready with cache_hit=0.
  - WB=0: no allocation; go to WTHRU.
- WBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_dout=victim data. On mem_ack, go to FILL (read) or install (write).
- FILL: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack: install mem_din into the victim (valid=1, dirty=0), update LRU, go to RESP.
- RESP: cpu_dout = filled data, cache_hit=0, pulse ready, go to IDLE.
- WTHRU: mem_req=1, mem_we=1, latched addr and data on the memory bus. On mem_ack, pulse ready. cache_hit reflects the LOOKUP result.
- Counters: every completed access increments exactly one of hit_cnt or miss_cnt. Each saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Reset (clr=0, asynchronous) forces:
  - all valid, dirty and LRU bits to 0; state to IDLE
  - cpu_ready, cache_hit, mem_req and mem_we to 0
  - cpu_dout, mem_addr, mem_dout and both counters to 0
- Reset mid-transaction: mem_req drops immediately and nothing is installed.
- All outputs are registered.
- Read-hit latency: cpu_req sampled at edge E0; cpu_ready is high for the cycle after E1.
- Miss latency: 2 cycles plus one memory round-trip per memory phase, plus 1 cycle for RESP.
- CPU handshake:
  - The requester holds cpu_req, cpu_we, cpu_addr and cpu_din stable until cpu_ready.
  - cpu_req is sampled only in IDLE.
  - A request still high at the edge ending the ready cycle counts as a new request.
- Memory handshake:
  - mem_addr, mem_we and mem_dout are stable while mem_req=1.
  - mem_ack is ignored while mem_req=0.
  - mem_req is low in the cycle after mem_ack is sampled; WBACK to FILL has a 1-cycle gap.
- A same-cycle counter increment at saturation leaves the counter at its maximum.

## Test plan
- Reset, then read 0x105 with memory returning 0xABCD after 3 cycles → FILL with mem_addr=0x105; cpu_dout=0xABCD, cache_hit=0, miss_cnt=1. Re-read 0x105 → cpu_ready 2 cycles after request, cache_hit=1, no mem_req.
- WB=1: read 0x105, then 0x205 (both ways in set 0x05 filled), write 0x105=0x1111, then read 0x305 → way holding 0x205 evicted, clean, no WBACK. Read 0x205 → WBACK of 0x105 data 0x1111, then FILL of 0x205.
- WB=1 write miss to a set whose victim is dirty → exactly one mem write (old address and data), no mem read; next read of that address hits with the new data.
- WB=0: write 0x010=0x5A5A while not cached → one memory write, no allocation; the following read of 0x010 misses.
- Assert clr=0 during FILL while mem_req=1 → mem_req=0 immediately, valid bits cleared; after release, read of the same address misses.
- Force hit_cnt to 0xFFFF (CNT_W=16), then one more hit → hit_cnt stays 0xFFFF and miss_cnt is unchanged.
